// File: rtl/serial_rbs_if.sv
// rtl/serial_rbs_if.sv - operand/result handshake bundle for the bit-serial subtractor
//
// Purpose : groups the start/busy/done handshake, operands and results of
//           serial_rbs so they can be passed as one port.
// Signals : start  - operation request (master -> slave)
//           a, b   - minuend / subtrahend, W bits (master -> slave)
//           bi     - borrow-in (master -> slave)
//           busy   - bits being processed (slave -> master)
//           done   - one-cycle completion pulse (slave -> master)
//           d      - difference, W bits (slave -> master)
//           bout   - borrow-out (slave -> master)
interface serial_rbs_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_rbs.sv
// rtl/serial_rbs.sv - bit-serial ripple-borrow subtractor, d = a - b - bi, LSB first
//
// Purpose : computes (a - b - bi) mod 2^W and the borrow-out one bit per clock
//           through a single registered borrow stage. Operands are captured on
//           an accepted start, busy is high for W cycles, then done pulses for
//           one cycle with d/bout valid. Results hold until the next completion.
// Ports   : clk    - rising-edge clock
//           rst_n  - synchronous active-low reset
//           bus    - serial_rbs_if.slave (start, a, b, bi, busy, done, d, bout)
module serial_rbs #(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_rbs_if.slave bus
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_d;
    logic          r_br;
    logic          r_bout;
    logic [CW-1:0] r_cnt;

    logic          w_ai;
    logic          w_bi;
    logic          w_diff;
    logic          w_br_next;
    logic          w_last;
    logic [W-1:0]  w_res_next;

    // Operand shift registers move right, so the current bit is always bit 0.
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_diff    = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last    = (r_cnt == CW'(W - 1));

    // New difference bit enters at the MSB; after W shifts bit 0 holds the
    // first (LSB) result bit. Written as a widened shift so it also works at W=1.
    assign w_res_next = W'({w_diff, r_res} >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts start directly so operations can run back to back.
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= bus.bi;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    if (w_last) begin
                        // Outputs only change here, so they stay stable during BUSY.
                        r_d     <= w_res_next;
                        r_bout  <= w_br_next;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state == S_BUSY);
    assign bus.done = (r_state == S_DONE);
    assign bus.d    = r_d;
    assign bus.bout = r_bout;

endmodule
